// File: rtl/iagc_pkg.sv
// Shared IAGC definitions: status codes, datapath widths and the gain-controller
// state encoding, used by amplitude_detector and iagc_gain_controller.
package iagc_pkg;

  localparam int IAGC_STATUS_SIZE    = 4;
  localparam int AMPLITUDE_DATA_SIZE = 14;
  localparam int GAIN_DATA_SIZE      = 16;
  localparam int SETTLE_COUNT_SIZE   = 16;
  localparam int LOCK_COUNT_SIZE     = 8;
  localparam int STEP_SHIFT          = 4;

  localparam logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_RESET = 4'b0000;
  localparam logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_INIT  = 4'b0001;

  typedef enum logic [1:0] {
    GC_IDLE    = 2'd0,
    GC_COMPARE = 2'd1,
    GC_UPDATE  = 2'd2,
    GC_SETTLE  = 2'd3
  } gc_state_e;

endpackage

// File: rtl/iagc_sat_addsub.sv
// Combinational saturating add/subtract of a step to the gain word; the sum is
// formed one bit wider so the carry/borrow out flags the clamp.
module iagc_sat_addsub
  import iagc_pkg::*;
(
  input  logic [GAIN_DATA_SIZE-1:0] i_gain,
  input  logic [GAIN_DATA_SIZE-1:0] i_step,
  input  logic                      i_sub,
  output logic [GAIN_DATA_SIZE-1:0] o_result,
  output logic                      o_clamp
);

  logic [GAIN_DATA_SIZE:0] sum_s;

  // Wide sum, then clamp to the rail in the direction of travel.
  always_comb begin
    if (i_sub) begin
      sum_s = {1'b0, i_gain} - {1'b0, i_step};
    end else begin
      sum_s = {1'b0, i_gain} + {1'b0, i_step};
    end
    if (sum_s[GAIN_DATA_SIZE]) begin
      o_clamp  = 1'b1;
      o_result = i_sub ? {GAIN_DATA_SIZE{1'b0}} : {GAIN_DATA_SIZE{1'b1}};
    end else begin
      o_clamp  = 1'b0;
      o_result = sum_s[GAIN_DATA_SIZE-1:0];
    end
  end

endmodule

// File: rtl/iagc_gain_controller.sv
// Closed-loop IAGC gain update: compare, step a saturating gain, settle, track lock.
// Optional macro IAGC_PROPORTIONAL_STEP_EN derives the step from |diff| >> STEP_SHIFT.
module iagc_gain_controller
  import iagc_pkg::*;
(
  input  logic                           i_clock,
  input  logic                           i_reset_n,
  input  logic [IAGC_STATUS_SIZE-1:0]    i_iagc_status,
  input  logic [AMPLITUDE_DATA_SIZE-1:0] i_reference_amplitude,
  input  logic [AMPLITUDE_DATA_SIZE-1:0] i_error_amplitude,
  input  logic                           i_valid,
  input  logic [AMPLITUDE_DATA_SIZE-1:0] i_tolerance,
  input  logic [GAIN_DATA_SIZE-1:0]      i_step,
  input  logic [GAIN_DATA_SIZE-1:0]      i_gain_init,
  input  logic [SETTLE_COUNT_SIZE-1:0]   i_settle_count,
  input  logic [LOCK_COUNT_SIZE-1:0]     i_lock_count,
  output logic [GAIN_DATA_SIZE-1:0]      o_gain,
  output logic                           o_gain_valid,
  output logic                           o_locked,
  output logic                           o_saturated
);

  localparam int AW = AMPLITUDE_DATA_SIZE;
  localparam int GW = GAIN_DATA_SIZE;
  localparam int SW = SETTLE_COUNT_SIZE;
  localparam int LW = LOCK_COUNT_SIZE;

  gc_state_e         state_q, state_d;
  logic [AW-1:0]     ref_q, ref_d, err_q, err_d;
  logic signed [AW:0] diff_q, diff_d, diff_s;
  logic [AW:0]       abs_s;
  logic              in_band_q, in_band_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [LW-1:0]     lock_cnt_q, lock_cnt_d, lock_inc_s, lock_thr_s;
  logic [GW-1:0]     gain_q, gain_d, step_s, sum_s;
  logic              locked_q, locked_d, sat_q, sat_d, upd_q, upd_d;
  logic              clamp_s, sub_s, soft_rst_s;
  logic [GW-1:0]     o_gain_q, o_gain_d;
  logic              o_gain_valid_q, o_gain_valid_d;
  logic              o_locked_q, o_locked_d, o_saturated_q, o_saturated_d;

  assign soft_rst_s = (i_iagc_status == IAGC_STATUS_RESET);
  assign diff_s     = $signed({1'b0, ref_q}) - $signed({1'b0, err_q});
  assign sub_s      = (diff_q < $signed({(AW + 1){1'b0}}));
  assign lock_inc_s = (lock_cnt_q == {LW{1'b1}}) ? lock_cnt_q : lock_cnt_q + {{(LW - 1){1'b0}}, 1'b1};
  assign lock_thr_s = (i_lock_count == {LW{1'b0}}) ? {{(LW - 1){1'b0}}, 1'b1} : i_lock_count;

  // Magnitude of the freshly formed difference.
  always_comb begin
    if (diff_s < $signed({(AW + 1){1'b0}})) begin
      abs_s = -diff_s;
    end else begin
      abs_s = diff_s;
    end
  end

`ifdef IAGC_PROPORTIONAL_STEP_EN
  logic [AW:0] abs_q, abs_d, shifted_s;

  // Proportional step, never allowed to collapse to zero.
  always_comb begin
    shifted_s = abs_q >> STEP_SHIFT;
    if (shifted_s == {(AW + 1){1'b0}}) begin
      step_s = {{(GW - 1){1'b0}}, 1'b1};
    end else begin
      step_s = GW'(shifted_s);
    end
  end
`else
  assign step_s = i_step;
`endif

  iagc_sat_addsub u_sat_addsub (
    .i_gain   (gain_q),
    .i_step   (step_s),
    .i_sub    (sub_s),
    .o_result (sum_s),
    .o_clamp  (clamp_s)
  );

  // Next-state and datapath; results computed in UPDATE are published one cycle later.
  always_comb begin
    state_d        = state_q;
    ref_d          = ref_q;
    err_d          = err_q;
    diff_d         = diff_q;
    in_band_d      = in_band_q;
`ifdef IAGC_PROPORTIONAL_STEP_EN
    abs_d          = abs_q;
`endif
    settle_d       = settle_q;
    lock_cnt_d     = lock_cnt_q;
    gain_d         = gain_q;
    locked_d       = locked_q;
    sat_d          = sat_q;
    upd_d          = 1'b0;
    o_gain_d       = o_gain_q;
    o_gain_valid_d = upd_q;
    o_locked_d     = o_locked_q;
    o_saturated_d  = o_saturated_q;
    if (soft_rst_s) begin
      state_d        = GC_IDLE;
      lock_cnt_d     = {LW{1'b0}};
      locked_d       = 1'b0;
      sat_d          = 1'b0;
      gain_d         = i_gain_init;
      o_gain_d       = i_gain_init;
      o_gain_valid_d = 1'b0;
      o_locked_d     = 1'b0;
      o_saturated_d  = 1'b0;
    end else begin
      if (upd_q) begin
        o_gain_d      = gain_q;
        o_locked_d    = locked_q;
        o_saturated_d = sat_q;
      end else begin
        o_gain_d      = o_gain_q;
      end
      case (state_q)
        GC_IDLE: begin
          if (i_valid) begin
            ref_d   = i_reference_amplitude;
            err_d   = i_error_amplitude;
            state_d = GC_COMPARE;
          end else begin
            state_d = GC_IDLE;
          end
        end
        GC_COMPARE: begin
          diff_d    = diff_s;
          in_band_d = (abs_s <= {1'b0, i_tolerance});
`ifdef IAGC_PROPORTIONAL_STEP_EN
          abs_d     = abs_s;
`endif
          state_d   = GC_UPDATE;
        end
        GC_UPDATE: begin
          upd_d    = 1'b1;
          settle_d = (i_settle_count == {SW{1'b0}}) ? {{(SW - 1){1'b0}}, 1'b1} : i_settle_count;
          state_d  = GC_SETTLE;
          if (in_band_q) begin
            lock_cnt_d = lock_inc_s;
            locked_d   = (lock_inc_s >= lock_thr_s);
            sat_d      = 1'b0;
          end else begin
            lock_cnt_d = {LW{1'b0}};
            locked_d   = 1'b0;
            gain_d     = sum_s;
            sat_d      = clamp_s;
          end
        end
        GC_SETTLE: begin
          if (settle_q <= {{(SW - 1){1'b0}}, 1'b1}) begin
            state_d = GC_IDLE;
          end else begin
            settle_d = settle_q - {{(SW - 1){1'b0}}, 1'b1};
          end
        end
        default: state_d = GC_IDLE;
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= GC_IDLE;
      ref_q          <= {AW{1'b0}};
      err_q          <= {AW{1'b0}};
      diff_q         <= {(AW + 1){1'b0}};
      in_band_q      <= 1'b0;
`ifdef IAGC_PROPORTIONAL_STEP_EN
      abs_q          <= {(AW + 1){1'b0}};
`endif
      settle_q       <= {SW{1'b0}};
      lock_cnt_q     <= {LW{1'b0}};
      gain_q         <= {GW{1'b0}};
      locked_q       <= 1'b0;
      sat_q          <= 1'b0;
      upd_q          <= 1'b0;
      o_gain_q       <= {GW{1'b0}};
      o_gain_valid_q <= 1'b0;
      o_locked_q     <= 1'b0;
      o_saturated_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      ref_q          <= ref_d;
      err_q          <= err_d;
      diff_q         <= diff_d;
      in_band_q      <= in_band_d;
`ifdef IAGC_PROPORTIONAL_STEP_EN
      abs_q          <= abs_d;
`endif
      settle_q       <= settle_d;
      lock_cnt_q     <= lock_cnt_d;
      gain_q         <= gain_d;
      locked_q       <= locked_d;
      sat_q          <= sat_d;
      upd_q          <= upd_d;
      o_gain_q       <= o_gain_d;
      o_gain_valid_q <= o_gain_valid_d;
      o_locked_q     <= o_locked_d;
      o_saturated_q  <= o_saturated_d;
    end
  end

  assign o_gain       = o_gain_q;
  assign o_gain_valid = o_gain_valid_q;
  assign o_locked     = o_locked_q;
  assign o_saturated  = o_saturated_q;

endmodule

// File: tb/tb_iagc_gain_controller.sv
// Self-checking bench for iagc_gain_controller: directed scenarios plus random
// traffic, all compared every cycle against a transaction-level reference model.
module tb_iagc_gain_controller;
  import iagc_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  status;
  logic [13:0] ref_a, err_a, tol;
  logic        valid;
  logic [15:0] step, ginit, settle;
  logic [7:0]  lockc;
  logic [15:0] o_gain;
  logic        o_gv, o_lk, o_sat;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: committed outputs plus one scheduled result event.
  int m_gain, m_cnt, next_acc, ev_cyc, ev_gain;
  bit m_lk, m_sat, m_gv, ev_pend, ev_lk, ev_sat;

`ifdef IAGC_PROPORTIONAL_STEP_EN
  localparam logic [15:0] EXP_UP  = 16'h401F;
  localparam logic [15:0] EXP_UP2 = 16'h4025;
  localparam logic [15:0] EXP_P   = 16'h1032;
`else
  localparam logic [15:0] EXP_UP  = 16'h4100;
  localparam logic [15:0] EXP_UP2 = 16'h4200;
  localparam logic [15:0] EXP_P   = 16'h1100;
`endif

  always #5 clk = ~clk;

  iagc_gain_controller dut (
    .i_clock               (clk),
    .i_reset_n             (rst_n),
    .i_iagc_status         (status),
    .i_reference_amplitude (ref_a),
    .i_error_amplitude     (err_a),
    .i_valid               (valid),
    .i_tolerance           (tol),
    .i_step                (step),
    .i_gain_init           (ginit),
    .i_settle_count        (settle),
    .i_lock_count          (lockc),
    .o_gain                (o_gain),
    .o_gain_valid          (o_gv),
    .o_locked              (o_lk),
    .o_saturated           (o_sat)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_gain = 0; m_cnt = 0; m_lk = 1'b0; m_sat = 1'b0; m_gv = 1'b0;
    ev_pend = 1'b0; next_acc = 0;
  endtask

  // Applies the specified per-transaction rules at each rising edge.
  task automatic model_edge();
    int d, ad, stp, ng, thr;
    cyc++;
    m_gv = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (status == IAGC_STATUS_RESET) begin
      m_gain = int'(ginit); m_cnt = 0; m_lk = 1'b0; m_sat = 1'b0;
      ev_pend = 1'b0; next_acc = cyc + 1;
    end else begin
      if (ev_pend && cyc == ev_cyc) begin
        m_gain = ev_gain; m_lk = ev_lk; m_sat = ev_sat; m_gv = 1'b1; ev_pend = 1'b0;
      end
      if (valid && cyc >= next_acc) begin
        d  = int'(ref_a) - int'(err_a);
        ad = (d < 0) ? -d : d;
        if (ad <= int'(tol)) begin
          m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
          thr     = (lockc == 8'd0) ? 1 : int'(lockc);
          ev_lk   = (m_cnt >= thr);
          ev_sat  = 1'b0;
          ev_gain = m_gain;
        end else begin
          m_cnt = 0;
          ev_lk = 1'b0;
`ifdef IAGC_PROPORTIONAL_STEP_EN
          stp = ((ad >> 4) == 0) ? 1 : (ad >> 4);
`else
          stp = int'(step);
`endif
          ng     = (d > 0) ? m_gain + stp : m_gain - stp;
          ev_sat = 1'b0;
          if (ng > 65535) begin
            ng = 65535; ev_sat = 1'b1;
          end else if (ng < 0) begin
            ng = 0; ev_sat = 1'b1;
          end
          ev_gain = ng;
        end
        ev_pend  = 1'b1;
        ev_cyc   = cyc + 3;
        next_acc = cyc + 3 + ((settle == 16'd0) ? 1 : int'(settle));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("gain",   32'(o_gain), 32'(m_gain));
    check_eq("gvalid", 32'(o_gv),   32'(m_gv));
    check_eq("locked", 32'(o_lk),   32'(m_lk));
    check_eq("sat",    32'(o_sat),  32'(m_sat));
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_gain", 32'(o_gain), 32'd0);
    check_eq("arst_gv",   32'(o_gv),   32'd0);
    check_eq("arst_lk",   32'(o_lk),   32'd0);
    check_eq("arst_sat",  32'(o_sat),  32'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
  endtask

  task automatic soft_rst(input logic [15:0] init, input int n);
    status = IAGC_STATUS_RESET;
    ginit  = init;
    repeat (n) tick();
    status = IAGC_STATUS_INIT;
  endtask

  task automatic txn(input int r, input int e);
    ref_a = 14'(r);
    err_a = 14'(e);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int pulses, early;
    status = IAGC_STATUS_INIT; ref_a = 14'd0; err_a = 14'd0; valid = 1'b0;
    tol = 14'd10; step = 16'h0100; ginit = 16'h0000; settle = 16'd1; lockc = 8'd3;
    model_reset();
    async_reset();

    soft_rst(16'h4000, 2);
    tick();
    check_eq("sr_gain", 32'(o_gain), 32'h4000);
    check_eq("sr_lock", 32'(o_lk), 32'd0);

    txn(1000, 500);
    check_eq("up_gv",   32'(o_gv), 32'd1);
    check_eq("up_gain", 32'(o_gain), 32'(EXP_UP));
    check_eq("up_lock", 32'(o_lk), 32'd0);

    txn(1000, 995);
    txn(1000, 995);
    check_eq("lock2", 32'(o_lk), 32'd0);
    txn(1000, 995);
    check_eq("lock3",      32'(o_lk), 32'd1);
    check_eq("lock3_gain", 32'(o_gain), 32'(EXP_UP));
    txn(1000, 900);
    check_eq("unlock",      32'(o_lk), 32'd0);
    check_eq("unlock_gain", 32'(o_gain), 32'(EXP_UP2));

    soft_rst(16'hFF80, 1);
    txn(4000, 0);
    check_eq("sat_hi_gain", 32'(o_gain), 32'hFFFF);
    check_eq("sat_hi_flag", 32'(o_sat), 32'd1);
    soft_rst(16'h0050, 1);
    txn(0, 4000);
    check_eq("sat_lo_gain", 32'(o_gain), 32'h0000);
    check_eq("sat_lo_flag", 32'(o_sat), 32'd1);
    txn(100, 100);
    check_eq("sat_clear", 32'(o_sat), 32'd0);

    settle = 16'd20; ref_a = 14'd1000; err_a = 14'd500;
    pulses = 0; early = 0;
    for (int k = 0; k < 28; k++) begin
      valid = (k == 0 || k == 10 || k == 23);
      tick();
      if (o_gv) begin
        pulses++;
        if (k < 23) early++;
      end
    end
    valid = 1'b0;
    check_eq("settle_drop", 32'(early), 32'd1);
    check_eq("settle_next", 32'(pulses), 32'd2);
    repeat (20) tick();

    ref_a = 14'd3000; err_a = 14'd100; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (6) tick();
    async_reset();

    settle = 16'd1; tol = 14'd10; step = 16'h0100;
    soft_rst(16'h1000, 1);
    txn(900, 100);
    check_eq("prop_gain", 32'(o_gain), 32'(EXP_P));

    for (int i = 0; i < 800; i++) begin
      if (cyc + 1 >= next_acc) begin
        tol    = 14'($urandom_range(0, 40));
        settle = 16'($urandom_range(0, 5));
        lockc  = 8'($urandom_range(0, 4));
        ref_a  = 14'($urandom);
        err_a  = ($urandom_range(0, 1) == 1) ? 14'(int'(ref_a) + $urandom_range(0, 60) - 30)
                                             : 14'($urandom);
        case ($urandom_range(0, 3))
          0:       step = 16'h0000;
          1:       step = 16'($urandom_range(1, 16));
          2:       step = 16'($urandom);
          default: step = 16'h0100;
        endcase
        case ($urandom_range(0, 2))
          0:       ginit = 16'hFFF0;
          1:       ginit = 16'h0008;
          default: ginit = 16'($urandom);
        endcase
      end
      valid  = ($urandom_range(0, 2) == 0);
      status = ($urandom_range(0, 49) == 0) ? IAGC_STATUS_RESET : IAGC_STATUS_INIT;
      tick();
    end
    valid  = 1'b0;
    status = IAGC_STATUS_INIT;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
